spi_xfer_seq: RTL
=================

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 16; depth of the receive FIFO, power of two, 2..16.
REQ-002 Parameter POLL_GAP, default 3; clk cycles between the start write and the first status poll.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid/req_ready  input/output  1/1  transaction handshake; a descriptor is accepted when both are 1 on the same clk edge.
REQ-006 req_cmd/req_addr/req_addr_en/req_len  input  8/24/1/5  command byte; address, sent MSB first; address enable; read byte count 1..16 (0 is treated as 1).
REQ-007 cfg_div/cfg_cpol/cfg_cpha  input  8/1/1  SPI clock divider and mode bits, sampled when a descriptor is accepted.
REQ-008 rx_valid/rx_ready/rx_data  output/input/output  1/1/8  receive FIFO pop handshake; first-word-fall-through.
REQ-009 busy/done  output  1/1  busy: a transaction is in progress; done: one-cycle pulse after chip select is released.
REQ-010 spi_waddr/spi_wdata/spi_sel/spi_we  output  8/32/4/1  write port into the SPI register block.
REQ-011 spi_raddr/spi_rd/spi_rdata  output/output/input  8/1/32  read port of the SPI register block; read data arrives one cycle after spi_rd.

Function
REQ-012 SPI register map used: CTRL 0x00 ([0] start, [1] CPOL, [2] CPHA, [3] chip select, [15:8] div); DATA 0x04 ([7:0]); STATUS 0x08 ([0] busy).
REQ-013 FSM states: IDLE, SEL, LOAD, START, GAP, POLL, PCHK, RDAT, RCHK, DESEL, DONE.
REQ-014 IDLE: req_ready=1. On acceptance, latch the descriptor and config, then go to SEL.
REQ-015 SEL: write CTRL with {div,0000,SS=1,cpha,cpol,start=0}, spi_sel=4'b0011, for one cycle, then go to LOAD.
REQ-016 Byte order: cmd; then addr[23:16], addr[15:8], addr[7:0] if addr_en; then req_len dummy bytes of 0x00.
REQ-017 LOAD: write DATA with the current byte, spi_sel=4'b1111. For a dummy byte with fewer than 2 free FIFO entries, stall in LOAD with no write until space is available.
REQ-018 START: write CTRL with the SEL value and start=1. Then GAP counts POLL_GAP cycles, during which spi_we=0.
REQ-019 POLL: assert spi_rd to STATUS for one cycle. PCHK: if spi_rdata[0]=1 return to POLL; otherwise go to RDAT for a dummy byte, or to LOAD/DESEL for a command/address byte.
REQ-020 RDAT: assert spi_rd to DATA. RCHK: push spi_rdata[7:0] into the FIFO. If more bytes remain go to LOAD, else go to DESEL.
REQ-021 DESEL: write CTRL with SS=0 and start=0. DONE: pulse done for one cycle, then return to IDLE.
REQ-022 Only one of spi_we and spi_rd is asserted per cycle. spi_wdata[31:16] is 0. Unused address bits are 0.
REQ-023 busy=1 in every state except IDLE; req_ready is the complement of busy.
REQ-024 FIFO behaviour:
  - count width is $clog2(FIFO_DEPTH)+1;
  - pointers wrap modulo FIFO_DEPTH;
  - a simultaneous push and pop leaves the count unchanged;
  - a pop when empty is ignored;
  - a push is never issued when full (guaranteed by REQ-017).
REQ-025 The FIFO is not flushed between transactions. Unread data stays ahead of new data.

Reset
REQ-026 On rst: FSM=IDLE, byte counter=0, GAP counter=0, FIFO empty, all latched descriptor fields=0.
REQ-027 On rst, outputs are: req_ready=1, busy=0, done=0, rx_valid=0, spi_we=0, spi_rd=0, spi_waddr=0, spi_wdata=0, spi_sel=0, spi_raddr=0.
REQ-028 Reset mid-transaction aborts immediately and drops FIFO contents. Chip select release is the responsibility of the SPI block's own reset.

Structure
REQ-029 The shared package holds:
  - SPI register offsets (0x00/0x04/0x08);
  - CTRL bit positions;
  - FSM state encoding (4-bit localparams).
REQ-030 The receive FIFO is one sub-module, spi_rx_fifo, with parameterised depth, synchronous push/pop and the asynchronous active-high rst.

Verification
REQ-031 cmd=0x03, addr=0x123456, addr_en=1, len=2; SPI model returns 0xA5, 0x5A -> MOSI bytes are 03,12,34,56,00,00; FIFO delivers A5 then 5A; exactly 6 start writes; one done pulse.
REQ-032 cmd=0x9F, addr_en=0, len=3 -> no address bytes; 4 start writes; 3 FIFO entries.
REQ-033 len=16, rx_ready=0 throughout, FIFO_DEPTH=4 -> FSM stalls in LOAD with 4 entries (count=4) after the 4th dummy byte; no overflow. Raising rx_ready resumes the transfer and all 16 bytes arrive in order.
REQ-034 Model holds busy for 40 cycles -> repeated POLL/PCHK; no spi_we asserted during polling; no early RDAT.
REQ-035 rst asserted while in GAP -> next cycle: IDLE, busy=0, rx_valid=0, spi_we=0.
REQ-036 req_valid held high across two back-to-back descriptors -> the second is accepted only in the cycle after done; req_len=0 behaves as len=1.

Source files
------------

// File: rtl/spi_xfer_seq_pkg.sv
// rtl/spi_xfer_seq_pkg.sv - shared register map, CTRL bit positions and FSM encoding
// Purpose: constants and helpers shared by spi_xfer_seq and its receive FIFO.
// Ports: none (package).
package spi_xfer_seq_pkg;

  // SPI register block offsets
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_DATA   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;

  // CTRL register bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_SS      = 3;
  localparam int CTRL_DIV_LSB = 8;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SEL   = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_START = 4'd3;
  localparam logic [3:0] ST_GAP   = 4'd4;
  localparam logic [3:0] ST_POLL  = 4'd5;
  localparam logic [3:0] ST_PCHK  = 4'd6;
  localparam logic [3:0] ST_RDAT  = 4'd7;
  localparam logic [3:0] ST_RCHK  = 4'd8;
  localparam logic [3:0] ST_DESEL = 4'd9;
  localparam logic [3:0] ST_DONE  = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_SEL   = ST_SEL,
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_GAP   = ST_GAP,
    S_POLL  = ST_POLL,
    S_PCHK  = ST_PCHK,
    S_RDAT  = ST_RDAT,
    S_RCHK  = ST_RCHK,
    S_DESEL = ST_DESEL,
    S_DONE  = ST_DONE
  } state_e;

  // Assemble a CTRL register word; upper 16 bits are always zero.
  function automatic logic [31:0] ctrl_word(input logic [7:0] div, input logic cpol,
                                            input logic cpha, input logic ss, input logic start);
    logic [31:0] w;
    w = '0;
    w[CTRL_DIV_LSB +: 8] = div;
    w[CTRL_SS]           = ss;
    w[CTRL_CPHA]         = cpha;
    w[CTRL_CPOL]         = cpol;
    w[CTRL_START]        = start;
    return w;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - first-word-fall-through receive byte FIFO
// Purpose: holds received SPI bytes until the consumer pops them.
// Ports: clk, rst (async, active-high); push/push_data write side;
//        pop/pop_data/valid first-word-fall-through read side; count = entries held.
module spi_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;

  // Popping an empty FIFO is a no-op; the sequencer never pushes when full.
  assign do_pop   = pop && (count != '0);
  assign valid    = (count != '0);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - SPI transaction sequencer driving an SPI register block
// Purpose: sends cmd, optional 24-bit address and dummy bytes one at a time through
//          the SPI block, polling its busy flag, and queues bytes read back.
// Ports: clk, rst (async, active-high);
//        req_valid/req_ready + req_cmd/req_addr/req_addr_en/req_len: descriptor handshake;
//        cfg_div/cfg_cpol/cfg_cpha: SPI clock config latched with the descriptor;
//        rx_valid/rx_ready/rx_data: receive FIFO pop (first-word-fall-through);
//        busy/done: transaction status; done pulses once after chip select release;
//        spi_waddr/spi_wdata/spi_sel/spi_we: register write port;
//        spi_raddr/spi_rd/spi_rdata: register read port (data one cycle after spi_rd).
module spi_xfer_seq
  import spi_xfer_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int POLL_GAP   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [23:0] req_addr,
  input  logic        req_addr_en,
  input  logic [4:0]  req_len,
  input  logic [7:0]  cfg_div,
  input  logic        cfg_cpol,
  input  logic        cfg_cpha,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  spi_waddr,
  output logic [31:0] spi_wdata,
  output logic [3:0]  spi_sel,
  output logic        spi_we,
  output logic [7:0]  spi_raddr,
  output logic        spi_rd,
  input  logic [31:0] spi_rdata
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, div_q;
  logic [23:0]   addr_q;
  logic          addr_en_q, cpol_q, cpha_q;
  logic [4:0]    len_q;
  logic [5:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          push_q;
  logic [7:0]    push_data_q;
  logic [CW-1:0] fifo_count;
  logic [5:0]    hdr_len, total_len, idx_inc;
  logic          is_dummy, last_byte, fifo_tight, accept;
  logic [7:0]    cur_byte;
  logic [31:0]   ctrl_sel, ctrl_go, ctrl_rel;
  logic          unused_rdata;

  assign unused_rdata = ^spi_rdata[31:8];

  assign busy      = (state_q != S_IDLE);
  assign req_ready = ~busy;
  assign accept    = req_valid && req_ready;

  assign hdr_len   = addr_en_q ? 6'd4 : 6'd1;
  assign total_len = hdr_len + {1'b0, len_q};
  assign is_dummy  = (idx_q >= hdr_len);
  assign idx_inc   = idx_q + 6'd1;
  assign last_byte = (idx_inc >= total_len);

  // The read byte is pushed one cycle after RCHK, so at LOAD one push may still be
  // in flight; two free entries cover that byte plus the one about to be sent.
  assign fifo_tight = (fifo_count >= CW'(FIFO_DEPTH - 1));

  assign ctrl_sel = ctrl_word(div_q, cpol_q, cpha_q, 1'b1, 1'b0);
  assign ctrl_go  = ctrl_word(div_q, cpol_q, cpha_q, 1'b1, 1'b1);
  assign ctrl_rel = ctrl_word(div_q, cpol_q, cpha_q, 1'b0, 1'b0);

  always_comb begin
    cur_byte = 8'h00;
    if (!is_dummy) begin
      case (idx_q[1:0])
        2'd0:    cur_byte = cmd_q;
        2'd1:    cur_byte = addr_q[23:16];
        2'd2:    cur_byte = addr_q[15:8];
        default: cur_byte = addr_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      addr_en_q   <= 1'b0;
      len_q       <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      push_q  <= (state_q == S_RCHK);
      if (state_q == S_RCHK) push_data_q <= spi_rdata[7:0];
      if (accept) begin
        cmd_q     <= req_cmd;
        addr_q    <= req_addr;
        addr_en_q <= req_addr_en;
        len_q     <= (req_len == 5'd0) ? 5'd1 : req_len;
        div_q     <= cfg_div;
        cpol_q    <= cfg_cpol;
        cpha_q    <= cfg_cpha;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    spi_we    = 1'b0;
    spi_waddr = '0;
    spi_wdata = '0;
    spi_sel   = '0;
    spi_rd    = 1'b0;
    spi_raddr = '0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SEL;
          idx_d   = '0;
        end
      end
      S_SEL: begin
        spi_we    = 1'b1;
        spi_waddr = REG_CTRL;
        spi_wdata = ctrl_sel;
        spi_sel   = 4'b0011;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        if (!(is_dummy && fifo_tight)) begin
          spi_we    = 1'b1;
          spi_waddr = REG_DATA;
          spi_wdata = {24'h0, cur_byte};
          spi_sel   = 4'b1111;
          state_d   = S_START;
        end
      end
      S_START: begin
        spi_we    = 1'b1;
        spi_waddr = REG_CTRL;
        spi_wdata = ctrl_go;
        spi_sel   = 4'b0011;
        gap_d     = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(POLL_GAP - 1)) state_d = S_POLL;
        else                            gap_d   = gap_q + 1'b1;
      end
      S_POLL: begin
        spi_rd    = 1'b1;
        spi_raddr = REG_STATUS;
        state_d   = S_PCHK;
      end
      S_PCHK: begin
        if (spi_rdata[0]) begin
          state_d = S_POLL;
        end else if (is_dummy) begin
          state_d = S_RDAT;
        end else begin
          idx_d   = idx_inc;
          state_d = last_byte ? S_DESEL : S_LOAD;
        end
      end
      S_RDAT: begin
        spi_rd    = 1'b1;
        spi_raddr = REG_DATA;
        state_d   = S_RCHK;
      end
      S_RCHK: begin
        idx_d   = idx_inc;
        state_d = last_byte ? S_DESEL : S_LOAD;
      end
      S_DESEL: begin
        spi_we    = 1'b1;
        spi_waddr = REG_CTRL;
        spi_wdata = ctrl_rel;
        spi_sel   = 4'b0011;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .valid     (rx_valid),
    .count     (fifo_count)
  );

endmodule
